// File: rtl/unidade_hazard.sv
`default_nettype none
// unidade_hazard: load-use and dependency hazard detection, and EX operand forward selects, for the 5-stage pipeline.
// Macro FORWARDING_EN enables bypassing; without it the unit is a full interlock. Revision 1.0
module unidade_hazard #(
  parameter int LARGURA_REG  = 5,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    idValido,
  input  logic [LARGURA_REG-1:0]  idRs,
  input  logic [LARGURA_REG-1:0]  idRt,
  input  logic                    idUsaRs,
  input  logic                    idUsaRt,
  input  logic [LARGURA_REG-1:0]  idRd,
  input  logic                    idEscreve,
  input  logic                    idLoad,
  input  logic                    flush,
  output logic [1:0]              forwardA,
  output logic [1:0]              forwardB,
  output logic                    stall,
  output logic [LARGURA_CONT-1:0] contadorStall
);

  localparam logic [LARGURA_CONT-1:0] CONT_UM = LARGURA_CONT'(1);

  logic [LARGURA_REG-1:0]  ex_dst, mem_dst, wb_dst;
  logic                    ex_wr, ex_load, mem_wr, mem_load, wb_wr;
  logic                    ex_vivo, mem_vivo;
  logic                    rs_ex, rt_ex, rs_mem, rt_mem;
  logic                    bolha;
  logic [LARGURA_CONT-1:0] contador;
  logic                    unused_estado;

  // A slot writing r0 is never a producer.
  assign ex_vivo  = ex_wr & (ex_dst != '0);
  assign mem_vivo = mem_wr & (mem_dst != '0);

  assign rs_ex  = idUsaRs & ex_vivo  & (idRs == ex_dst);
  assign rt_ex  = idUsaRt & ex_vivo  & (idRt == ex_dst);
  assign rs_mem = idUsaRs & mem_vivo & (idRs == mem_dst);
  assign rt_mem = idUsaRt & mem_vivo & (idRt == mem_dst);

`ifdef FORWARDING_EN
  assign stall = idValido & ~flush & ex_load & (rs_ex | rt_ex);
`else
  // Regfile writes in the first half-cycle, so only EX and MEM producers block.
  assign stall = idValido & ~flush & (rs_ex | rt_ex | rs_mem | rt_mem);
`endif

  assign bolha = flush | stall | ~idValido;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_dst   <= '0;
      ex_wr    <= 1'b0;
      ex_load  <= 1'b0;
      mem_dst  <= '0;
      mem_wr   <= 1'b0;
      mem_load <= 1'b0;
      wb_dst   <= '0;
      wb_wr    <= 1'b0;
      contador <= '0;
    end else begin
      wb_dst   <= mem_dst;
      wb_wr    <= mem_wr;
      mem_dst  <= ex_dst;
      mem_wr   <= ex_wr;
      mem_load <= ex_load;
      if (bolha) begin
        ex_dst  <= '0;
        ex_wr   <= 1'b0;
        ex_load <= 1'b0;
      end else begin
        ex_dst  <= idRd;
        ex_wr   <= idEscreve;
        ex_load <= idLoad;
      end
      if (stall && (contador != '1)) begin
        contador <= contador + CONT_UM;
      end
    end
  end

  assign contadorStall = contador;

`ifdef FORWARDING_EN
  logic [1:0] fwd_a, fwd_b, fwd_a_prox, fwd_b_prox;

  // A matching load in EX always stalls, so the !ex_load test only matters for non-stalling paths.
  always_comb begin
    fwd_a_prox = 2'b00;
    fwd_b_prox = 2'b00;
    if (!bolha) begin
      if (rs_ex && !ex_load) fwd_a_prox = 2'b10;
      else if (rs_mem)       fwd_a_prox = 2'b01;
      if (rt_ex && !ex_load) fwd_b_prox = 2'b10;
      else if (rt_mem)       fwd_b_prox = 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fwd_a <= 2'b00;
      fwd_b <= 2'b00;
    end else begin
      fwd_a <= fwd_a_prox;
      fwd_b <= fwd_b_prox;
    end
  end

  assign forwardA      = fwd_a;
  assign forwardB      = fwd_b;
  assign unused_estado = ^{mem_load, wb_dst, wb_wr};
`else
  assign forwardA      = 2'b00;
  assign forwardB      = 2'b00;
  assign unused_estado = ^{ex_load, mem_load, wb_dst, wb_wr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_unidade_hazard.sv
`default_nettype none
// tb_unidade_hazard: directed vector table plus randomized run against a pipeline-occupancy model.
// Revision 1.0
module tb_unidade_hazard;

  localparam int CONT_MAX = 65535;

  logic       clock = 1'b0;
  logic       reset_n, idValido, idUsaRs, idUsaRt, idEscreve, idLoad, flush;
  logic [4:0] idRs, idRt, idRd;
  logic [1:0] forwardA, forwardB;
  logic       stall;
  logic [15:0] contadorStall;

  unidade_hazard #(.LARGURA_REG(5), .LARGURA_CONT(16)) dut (
    .clock(clock), .reset_n(reset_n), .idValido(idValido),
    .idRs(idRs), .idRt(idRt), .idUsaRs(idUsaRs), .idUsaRt(idUsaRt),
    .idRd(idRd), .idEscreve(idEscreve), .idLoad(idLoad), .flush(flush),
    .forwardA(forwardA), .forwardB(forwardB), .stall(stall),
    .contadorStall(contadorStall)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rn, v, ur, ut, we, ld, fl, chk;
    logic [4:0] rs, rt, rd;
    bit st;
    logic [1:0] fa, fb;
    int cnt;
  } vec_t;

  typedef struct {
    logic [4:0] dst;
    bit wr;
    bit ld;
  } slot_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  tab[$];
  slot_t pipe[3];          // in-flight instructions: 0=EX, 1=MEM, 2=WB
  logic [1:0] m_fa = 2'b00, m_fb = 2'b00;
  int    m_cnt = 0;

  function automatic vec_t mk(int rn, int v, int rs, int ur, int rt, int ut, int rd, int we,
                              int ld, int fl, int chk, int st, int fa, int fb, int cnt);
    vec_t t;
    t.rn = (rn != 0); t.v = (v != 0); t.ur = (ur != 0); t.ut = (ut != 0);
    t.we = (we != 0); t.ld = (ld != 0); t.fl = (fl != 0); t.chk = (chk != 0);
    t.rs = 5'(rs); t.rt = 5'(rt); t.rd = 5'(rd);
    t.st = (st != 0); t.fa = 2'(fa); t.fb = 2'(fb); t.cnt = cnt;
    return t;
  endfunction

  task automatic confere(input string nome, input int idx, input logic [31:0] atual,
                         input logic [31:0] esperado);
    n_checks++;
    if (atual !== esperado) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nome, idx, atual, esperado);
    end
  endtask

  // Does source r depend on an instruction the pipeline cannot yet supply?
  function automatic bit bloqueia(logic [4:0] r, bit usa);
    if (!usa || r == 5'd0) return 1'b0;
`ifdef FORWARDING_EN
    return pipe[0].wr && pipe[0].ld && pipe[0].dst == r;
`else
    return (pipe[0].wr && pipe[0].dst == r) || (pipe[1].wr && pipe[1].dst == r);
`endif
  endfunction

  // Nearest producer wins: distance 1 -> EX/MEM result, distance 2 -> WB, further -> regfile.
  function automatic logic [1:0] selecao(logic [4:0] r, bit usa);
`ifdef FORWARDING_EN
    if (!usa || r == 5'd0) return 2'b00;
    for (int k = 0; k < 2; k++)
      if (pipe[k].wr && pipe[k].dst == r) return (k == 0) ? 2'b10 : 2'b01;
`else
    if (usa && r == 5'd31) return 2'b00;
`endif
    return 2'b00;
  endfunction

  task automatic aplica(input vec_t t, input bit tabela, input int idx);
    bit st_m, avanca;
    reset_n = t.rn; idValido = t.v; idRs = t.rs; idRt = t.rt;
    idUsaRs = t.ur; idUsaRt = t.ut; idRd = t.rd; idEscreve = t.we;
    idLoad = t.ld; flush = t.fl;
    #3;
    st_m = t.v && !t.fl && (bloqueia(t.rs, t.ur) || bloqueia(t.rt, t.ut));
    if (tabela) begin
      if (t.chk) confere("stall", idx, 32'(stall), 32'(t.st));
    end else begin
      confere("rand_stall", idx, 32'(stall), 32'(st_m));
    end
    @(posedge clock);
    #1;
    if (!t.rn) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 1'b0, 1'b0};
      m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
    end else begin
      avanca = t.v && !t.fl && !st_m;
      m_fa = avanca ? selecao(t.rs, t.ur) : 2'b00;
      m_fb = avanca ? selecao(t.rt, t.ut) : 2'b00;
      if (st_m && m_cnt < CONT_MAX) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = avanca ? '{t.rd, t.we, t.ld} : '{5'd0, 1'b0, 1'b0};
    end
    if (tabela) begin
      confere("forwardA", idx, 32'(forwardA), 32'(t.fa));
      confere("forwardB", idx, 32'(forwardB), 32'(t.fb));
      confere("contadorStall", idx, 32'(contadorStall), 32'(t.cnt));
    end else begin
      confere("rand_forwardA", idx, 32'(forwardA), 32'(m_fa));
      confere("rand_forwardB", idx, 32'(forwardB), 32'(m_fb));
      confere("rand_contadorStall", idx, 32'(contadorStall), 32'(m_cnt));
    end
  endtask

  initial begin
    vec_t t;
    for (int k = 0; k < 3; k++) pipe[k] = '{5'd0, 1'b0, 1'b0};

    // rn v rs ur rt ut rd we ld fl | chk stall fa fb cnt   (fa/fb/cnt seen after the edge)
    tab.push_back(mk(0,1, 1,1, 1,1, 7,1,1,0, 0,0, 0,0,0));
    tab.push_back(mk(0,1, 7,1, 7,1, 7,1,1,0, 1,0, 0,0,0));
`ifdef FORWARDING_EN
    tab.push_back(mk(1,1, 0,0, 0,0, 3,1,0,0, 1,0, 0,0,0));   // add r3
    tab.push_back(mk(1,1, 3,1, 1,1, 6,1,0,0, 1,0, 2,0,0));   // sub r3 -> EX bypass
    tab.push_back(mk(1,0, 3,1, 1,1, 6,1,0,0, 1,0, 0,0,0));   // nop
    tab.push_back(mk(1,1, 0,0, 0,0, 5,1,0,0, 1,0, 0,0,0));   // add r5
    tab.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 1,0, 0,0,0));   // nop
    tab.push_back(mk(1,1, 2,1, 5,1, 8,1,0,0, 1,0, 0,1,0));   // or rt=r5 -> WB bypass
    tab.push_back(mk(1,1, 0,0, 0,0, 0,1,0,0, 1,0, 0,0,0));   // write r0
    tab.push_back(mk(1,1, 0,1, 0,1, 9,1,0,0, 1,0, 0,0,0));   // read r0 twice
    tab.push_back(mk(1,1, 9,1, 0,0, 9,1,0,0, 1,0, 2,0,0));
    tab.push_back(mk(1,1, 9,1, 9,1,10,0,0,0, 1,0, 2,2,0));   // EX beats MEM
    tab.push_back(mk(1,1, 0,0, 0,0, 4,1,1,0, 1,0, 0,0,0));   // lw r4
    tab.push_back(mk(1,1, 4,1, 7,1,11,1,0,0, 1,1, 0,0,1));   // load-use stall
    tab.push_back(mk(1,1, 4,1, 7,1,11,1,0,0, 1,0, 1,0,1));
    tab.push_back(mk(1,1, 0,0, 0,0,12,1,1,0, 1,0, 0,0,1));   // lw r12
    tab.push_back(mk(1,1, 0,0,12,1,13,1,0,1, 1,0, 0,0,1));   // flush beats stall
    tab.push_back(mk(1,1, 0,0,12,1,13,1,0,0, 1,0, 0,1,1));
    tab.push_back(mk(1,1, 0,0, 0,0,14,1,1,0, 1,0, 0,0,1));   // lw r14
    tab.push_back(mk(0,1, 0,0,14,1,15,1,0,0, 1,1, 0,0,0));   // reset mid-stall
    tab.push_back(mk(1,1, 0,0,14,1,15,1,0,0, 1,0, 0,0,0));
`else
    tab.push_back(mk(1,1, 0,0, 0,0, 3,1,0,0, 1,0, 0,0,0));   // add r3
    tab.push_back(mk(1,1, 3,1, 1,1, 6,1,0,0, 1,1, 0,0,1));   // consumer held two cycles
    tab.push_back(mk(1,1, 3,1, 1,1, 6,1,0,0, 1,1, 0,0,2));
    tab.push_back(mk(1,1, 3,1, 1,1, 6,1,0,0, 1,0, 0,0,2));
    tab.push_back(mk(1,1, 0,0, 0,0, 5,1,0,0, 1,0, 0,0,2));   // add r5
    tab.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 1,0, 0,0,2));   // nop
    tab.push_back(mk(1,1, 2,1, 5,1, 8,1,0,0, 1,1, 0,0,3));   // distance 2: one stall
    tab.push_back(mk(1,1, 2,1, 5,1, 8,1,0,0, 1,0, 0,0,3));
    tab.push_back(mk(1,1, 0,0, 0,0, 0,1,0,0, 1,0, 0,0,3));   // write r0
    tab.push_back(mk(1,1, 0,1, 0,1, 9,1,0,0, 1,0, 0,0,3));   // read r0 twice
    tab.push_back(mk(1,1, 0,0, 0,0, 4,1,1,0, 1,0, 0,0,3));   // lw r4
    tab.push_back(mk(1,1, 4,1, 7,1,11,1,0,0, 1,1, 0,0,4));
    tab.push_back(mk(1,1, 4,1, 7,1,11,1,0,0, 1,1, 0,0,5));
    tab.push_back(mk(1,1, 4,1, 7,1,11,1,0,0, 1,0, 0,0,5));
    tab.push_back(mk(1,1, 0,0, 0,0,12,1,1,0, 1,0, 0,0,5));   // lw r12
    tab.push_back(mk(1,1, 0,0,12,1,13,1,0,1, 1,0, 0,0,5));   // flush beats stall
    tab.push_back(mk(1,1, 0,0,12,1,13,1,0,0, 1,1, 0,0,6));
    tab.push_back(mk(1,1, 0,0,12,1,13,1,0,0, 1,0, 0,0,6));
    tab.push_back(mk(1,1, 0,0, 0,0,14,1,1,0, 1,0, 0,0,6));   // lw r14
    tab.push_back(mk(0,1, 0,0,14,1,15,1,0,0, 1,1, 0,0,0));   // reset mid-stall
    tab.push_back(mk(1,1, 0,0,14,1,15,1,0,0, 1,0, 0,0,0));
`endif

    for (int i = 0; i < tab.size(); i++) aplica(tab[i], 1'b1, i);

    for (int i = 0; i < 2000; i++) begin
      t = mk(($urandom_range(0, 149) != 0), ($urandom_range(0, 4) != 0),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
             1, 0, 0, 0, 0);
      aplica(t, 1'b0, i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
